// File: rtl/instr_mem_loader.sv
// Instruction-memory writer: packs big-endian bytes from the UART receiver into
// words and stores them at consecutive addresses until a halt word or a full memory.
module instr_mem_loader #(
  parameter int                NB_DATA   = 32,
  parameter int                NB_BYTE   = 8,
  parameter int                NB_ADDR   = 7,
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_i,
  input  logic [NB_BYTE-1:0] rx_data_i,
  input  logic               rx_done_i,
  output logic               wr_en_o,
  output logic [NB_ADDR-1:0] wr_addr_o,
  output logic [NB_DATA-1:0] wr_data_o,
  output logic [NB_ADDR:0]   word_count_o,
  output logic               loading_o,
  output logic               done_o,
  output logic               overflow_o
);

  localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
  localparam int NB_BCNT        = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(BYTES_PER_WORD - 1);
  localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } state_t;

  state_t                     state;
  logic [NB_BCNT-1:0]         byte_cnt;
  logic [NB_DATA-NB_BYTE-1:0] assembly;
  logic [NB_ADDR-1:0]         addr;
  logic [NB_DATA-1:0]         next_word;

  // The top byte of a word never needs storing: it is shifted straight out into wr_data_o.
  assign next_word = {assembly, rx_data_i};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      assembly     <= '0;
      addr         <= '0;
      wr_en_o      <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
      word_count_o <= '0;
      loading_o    <= 1'b0;
      done_o       <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          wr_en_o <= 1'b0;
          if (start_i) begin
            state        <= RECV;
            addr         <= '0;
            byte_cnt     <= '0;
            word_count_o <= '0;
            done_o       <= 1'b0;
            overflow_o   <= 1'b0;
            loading_o    <= 1'b1;
          end
        end

        RECV: begin
          if (rx_done_i) begin
            assembly <= next_word[NB_DATA-NB_BYTE-1:0];
            if (byte_cnt == LAST_BYTE) begin
              state     <= WRITE;
              byte_cnt  <= '0;
              wr_en_o   <= 1'b1;
              wr_addr_o <= addr;
              wr_data_o <= next_word;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end

        WRITE: begin
          wr_en_o      <= 1'b0;
          word_count_o <= word_count_o + 1'b1;
          if (wr_data_o == HALT_WORD) begin
            state      <= DONE;
            done_o     <= 1'b1;
            loading_o  <= 1'b0;
            overflow_o <= 1'b0;
          end else if (addr == LAST_ADDR) begin
            state      <= DONE;
            done_o     <= 1'b1;
            loading_o  <= 1'b0;
            overflow_o <= 1'b1;
          end else begin
            state <= RECV;
            addr  <= addr + 1'b1;
            // A strobe landing in this cycle is the first byte of the next word.
            if (rx_done_i) begin
              assembly <= next_word[NB_DATA-NB_BYTE-1:0];
              byte_cnt <= NB_BCNT'(1);
            end
          end
        end

        default: begin
          state   <= IDLE;
          wr_en_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: hand-computed write addresses/data,
// counters and status flags, with a monitor capturing every memory write.
module tb_instr_mem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_done_i = 1'b0;
  logic        wr_en_o;
  logic [6:0]  wr_addr_o;
  logic [31:0] wr_data_o;
  logic [7:0]  word_count_o;
  logic        loading_o;
  logic        done_o;
  logic        overflow_o;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  instr_mem_loader #(
    .NB_DATA  (32),
    .NB_BYTE  (8),
    .NB_ADDR  (7),
    .HALT_WORD(32'hFFFF_FFFF)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start_i     (start_i),
    .rx_data_i   (rx_data_i),
    .rx_done_i   (rx_done_i),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .word_count_o(word_count_o),
    .loading_o   (loading_o),
    .done_o      (done_o),
    .overflow_o  (overflow_o)
  );

  always #5 clock = ~clock;

  // Memory-side monitor: records each write seen mid-cycle.
  always @(negedge clock) begin
    if (wr_en_o) begin
      wr_addr_q.push_back(wr_addr_o);
      wr_data_q.push_back(wr_data_o);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic start_pulse();
    @(negedge clock);
    start_i = 1'b1;
    @(negedge clock);
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_data_i = b;
    rx_done_i = 1'b1;
    @(negedge clock);
    rx_done_i = 1'b0;
  endtask

  // Spaced bytes, then one more cycle so the write has completed.
  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    @(negedge clock);
  endtask

  // Four consecutive strobes; the write cycle overlaps the next idle slot.
  task automatic send_word_burst(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) begin
      @(negedge clock);
      rx_data_i = w[i*8 +: 8];
      rx_done_i = 1'b1;
    end
    @(negedge clock);
    rx_done_i = 1'b0;
  endtask

  task automatic apply_stimulus_burst(input int n, input logic [7:0] first);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      rx_data_i = first + 8'(i);
      rx_done_i = 1'b1;
    end
    @(negedge clock);
    rx_done_i = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int addr_bad;

    // Reset state
    repeat (3) @(negedge clock);
    check_output("rst_wr_en", wr_en_o, 0);
    check_output("rst_wr_addr", wr_addr_o, 0);
    check_output("rst_wr_data", wr_data_o, 0);
    check_output("rst_count", word_count_o, 0);
    check_output("rst_loading", loading_o, 0);
    check_output("rst_done", done_o, 0);
    check_output("rst_overflow", overflow_o, 0);
    reset = 1'b1;

    // Strobes in IDLE are ignored
    for (int i = 0; i < 4; i++) send_byte(8'h11);
    @(negedge clock);
    check_output("idle_nwrites", wr_data_q.size(), 0);
    check_output("idle_loading", loading_o, 0);

    // First word
    start_pulse();
    check_output("t1_loading_start", loading_o, 1);
    send_word(32'h2008_0005);
    check_output("t1_nwrites", wr_data_q.size(), 1);
    check_output("t1_addr", wr_addr_q[0], 0);
    check_output("t1_data", wr_data_q[0], 32'h2008_0005);
    check_output("t1_count", word_count_o, 1);
    check_output("t1_loading", loading_o, 1);
    check_output("t1_wr_en_low", wr_en_o, 0);

    // Two more words, then the halt word
    send_word(32'h1234_5678);
    send_word(32'hDEAD_BEEF);
    send_word(32'hFFFF_FFFF);
    check_output("t2_nwrites", wr_data_q.size(), 4);
    check_output("t2_addr1", wr_addr_q[1], 1);
    check_output("t2_data1", wr_data_q[1], 32'h1234_5678);
    check_output("t2_addr2", wr_addr_q[2], 2);
    check_output("t2_data2", wr_data_q[2], 32'hDEAD_BEEF);
    check_output("t2_addr3", wr_addr_q[3], 3);
    check_output("t2_data3", wr_data_q[3], 32'hFFFF_FFFF);
    check_output("t2_done", done_o, 1);
    check_output("t2_count", word_count_o, 4);
    check_output("t2_overflow", overflow_o, 0);
    check_output("t2_loading", loading_o, 0);

    // Strobes in DONE are ignored
    for (int i = 0; i < 4; i++) send_byte(8'h22);
    @(negedge clock);
    check_output("done_nwrites", wr_data_q.size(), 4);
    check_output("done_count", word_count_o, 4);
    check_output("done_hold", done_o, 1);

    // Restart from DONE
    start_pulse();
    check_output("t6_done_clear", done_o, 0);
    check_output("t6_count_clear", word_count_o, 0);
    check_output("t6_loading", loading_o, 1);
    wr_addr_q.delete();
    wr_data_q.delete();

    // Back-to-back strobes 01..08, byte 5 in the write cycle
    apply_stimulus_burst(8, 8'h01);
    check_output("t4_nwrites", wr_data_q.size(), 2);
    check_output("t4_addr0", wr_addr_q[0], 0);
    check_output("t4_data0", wr_data_q[0], 32'h0102_0304);
    check_output("t4_addr1", wr_addr_q[1], 1);
    check_output("t4_data1", wr_data_q[1], 32'h0506_0708);
    check_output("t4_count", word_count_o, 2);

    // Asynchronous reset after two bytes of a word
    send_byte(8'h77);
    send_byte(8'h66);
    #2 reset = 1'b0;
    #1;
    check_output("t5_loading", loading_o, 0);
    check_output("t5_count", word_count_o, 0);
    check_output("t5_wr_data", wr_data_o, 0);
    check_output("t5_wr_addr", wr_addr_o, 0);
    @(negedge clock);
    reset = 1'b1;
    start_pulse();
    wr_addr_q.delete();
    wr_data_q.delete();
    send_word(32'hAABB_CCDD);
    check_output("t5_nwrites", wr_data_q.size(), 1);
    check_output("t5_addr", wr_addr_q[0], 0);
    check_output("t5_data", wr_data_q[0], 32'hAABB_CCDD);
    send_word(32'hFFFF_FFFF);
    check_output("t5_done", done_o, 1);
    check_output("t5_count_end", word_count_o, 2);

    // Fill all 128 locations without a halt word
    start_pulse();
    wr_addr_q.delete();
    wr_data_q.delete();
    for (int i = 0; i < 128; i++) send_word_burst(32'h1000_0000 + 32'(i));
    @(negedge clock);
    check_output("t3_nwrites", wr_data_q.size(), 128);
    addr_bad = 0;
    foreach (wr_addr_q[k]) if (wr_addr_q[k] !== k[6:0]) addr_bad++;
    check_output("t3_addr_seq", addr_bad, 0);
    check_output("t3_last_addr", wr_addr_q[127], 127);
    check_output("t3_first_data", wr_data_q[0], 32'h1000_0000);
    check_output("t3_last_data", wr_data_q[127], 32'h1000_007F);
    check_output("t3_done", done_o, 1);
    check_output("t3_overflow", overflow_o, 1);
    check_output("t3_count", word_count_o, 128);
    check_output("t3_loading", loading_o, 0);
    apply_stimulus_burst(4, 8'h40);
    check_output("t3_extra_nwrites", wr_data_q.size(), 128);
    check_output("t3_extra_count", word_count_o, 128);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
